// File: rtl/eco32_core_ifu_icm_pkg.sv
`default_nettype none
// ==== eco32_core_ifu_icm_pkg : shared constants for the I-cache miss table / rev 1.0 ====
package eco32_core_ifu_icm_pkg;

  localparam int ICM_ENTRIES = 16;
  localparam int ICM_PTR_W   = 4;

  typedef enum logic [0:0] {
    ICM_IDLE = 1'b0,
    ICM_REQ  = 1'b1
  } icm_state_e;

  localparam logic TAG_LIVE = 1'b1;
  localparam logic TAG_FREE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/eco32_core_ifu_icm_freeenc.sv
`default_nettype none
// ==== eco32_core_ifu_icm_freeenc : lowest-clear-bit priority encoder / rev 1.0 ====
module eco32_core_ifu_icm_freeenc
  import eco32_core_ifu_icm_pkg::*;
(
  input  logic [ICM_ENTRIES-1:0] busy,
  output logic [ICM_PTR_W-1:0]   ptr,
  output logic                   any_free
);

  // Scan high to low so the last hit (the lowest free index) wins.
  always_comb begin
    ptr = '0;
    for (int i = ICM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) ptr = ICM_PTR_W'(i);
    end
    any_free = ~&busy;
  end

endmodule
`default_nettype wire

// File: rtl/eco32_core_ifu_icm_alloc.sv
`default_nettype none
// ==== eco32_core_ifu_icm_alloc : miss-table slot allocator, fill issue, release / rev 1.0 ====
module eco32_core_ifu_icm_alloc
  import eco32_core_ifu_icm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_stb,
  input  logic [31:6]          miss_v_addr,
  input  logic [3:0]           miss_asid,
  input  logic                 miss_wid,
  input  logic                 miss_tid,
  output logic                 miss_ack,
  output logic [ICM_PTR_W-1:0] miss_ptr,
  output logic                 tab_wr_stb,
  output logic [ICM_PTR_W-1:0] tab_wr_ptr,
  output logic [31:6]          tab_wr_v_addr,
  output logic [3:0]           tab_wr_asid,
  output logic                 tab_wr_wid,
  output logic                 tab_wr_tag,
  output logic                 tab_wr_tid,
  output logic                 mem_req_stb,
  output logic [ICM_PTR_W-1:0] mem_req_ptr,
  output logic [31:6]          mem_req_v_addr,
  input  logic                 mem_req_ack,
  input  logic                 rel_stb,
  input  logic [ICM_PTR_W-1:0] rel_ptr,
  output logic [4:0]           busy_cnt,
  output logic                 full
);

  icm_state_e             state, state_nxt;
  logic [ICM_ENTRIES-1:0] busy, busy_nxt;
  logic [4:0]             cnt_nxt;
  logic [ICM_PTR_W-1:0]   free_ptr;
  logic                   any_free;
  logic                   alloc;
  logic                   rel_ok;

  eco32_core_ifu_icm_freeenc u_freeenc (
    .busy     (busy),
    .ptr      (free_ptr),
    .any_free (any_free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ICM_IDLE;
    else     state <= state_nxt;
  end

  // Any rel_stb, accepted or not, defers the alloc so the write port never double-books.
  always_comb begin
    alloc     = (state == ICM_IDLE) && miss_stb && !full && any_free && !rel_stb;
    rel_ok    = rel_stb && busy[rel_ptr];
    state_nxt = state;
    case (state)
      ICM_IDLE: if (alloc)       state_nxt = ICM_REQ;
      ICM_REQ:  if (mem_req_ack) state_nxt = ICM_IDLE;
      default:                   state_nxt = ICM_IDLE;
    endcase
    busy_nxt = busy;
    if (alloc)  busy_nxt[free_ptr] = 1'b1;
    if (rel_ok) busy_nxt[rel_ptr]  = 1'b0;
    cnt_nxt = busy_cnt + 5'(alloc) - 5'(rel_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= '0;
      busy_cnt       <= '0;
      full           <= 1'b0;
      miss_ack       <= 1'b0;
      miss_ptr       <= '0;
      tab_wr_stb     <= 1'b0;
      tab_wr_ptr     <= '0;
      tab_wr_v_addr  <= '0;
      tab_wr_asid    <= '0;
      tab_wr_wid     <= 1'b0;
      tab_wr_tag     <= TAG_FREE;
      tab_wr_tid     <= 1'b0;
      mem_req_stb    <= 1'b0;
      mem_req_ptr    <= '0;
      mem_req_v_addr <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt   <= cnt_nxt;
      full       <= (cnt_nxt == 5'(ICM_ENTRIES));
      miss_ack   <= alloc;
      tab_wr_stb <= alloc | rel_ok;
      if (alloc) begin
        miss_ptr       <= free_ptr;
        tab_wr_ptr     <= free_ptr;
        tab_wr_v_addr  <= miss_v_addr;
        tab_wr_asid    <= miss_asid;
        tab_wr_wid     <= miss_wid;
        tab_wr_tag     <= TAG_LIVE;
        tab_wr_tid     <= miss_tid;
        mem_req_stb    <= 1'b1;
        mem_req_ptr    <= free_ptr;
        mem_req_v_addr <= miss_v_addr;
      end else begin
        // Release writes carry only the index; the rest of the entry is zeroed.
        tab_wr_ptr    <= rel_ok ? rel_ptr : '0;
        tab_wr_v_addr <= '0;
        tab_wr_asid   <= '0;
        tab_wr_wid    <= 1'b0;
        tab_wr_tag    <= TAG_FREE;
        tab_wr_tid    <= 1'b0;
        if (state == ICM_REQ && mem_req_ack) mem_req_stb <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
